// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   It does four jobs:
//   - Freezes the whole pipe while the data memory is busy with the access held in EX/MEM.
//   - Flushes the younger stages when EX resolves a taken branch.
//   - Inserts a single bubble for a load-use hazard.
//   - Keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.
//   The outputs are combinational from the state and the current inputs.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt         source registers of the instruction in ID
//   idex_mem_read        instruction in EX is a load
//   idex_rt              destination register of that load
//   ex_branch_taken      branch/jump in EX resolved taken
//   exmem_mem_read/write MEM-stage instruction accesses data memory
//   dmem_ready           data memory completes the access this cycle
//   dmem_req             data memory request
//   pc_en, ifid_en, idex_en, exmem_en   PC and pipeline register enables
//   ifid_flush           clear IF/ID to NOP on next edge
//   idex_flush           clear ID/EX control bits (bubble)
//   memwb_bubble         load MEM/WB with RegWrite=0
//   stall_count          saturating count of frozen cycles
//   mem_err              sticky flag: an access was aborted on timeout
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             ex_branch_taken,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_t;

  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] waitCnt;
  logic            memOp;
  logic            memStall;
  logic            branchFlush;
  logic            loadUse;

  always_comb begin
    memOp    = exmem_mem_read | exmem_mem_write;
    // On the last wait cycle the access is abandoned, so the pipe is released
    // rather than stalled.
    memStall = ((state == RUN) & memOp & ~dmem_ready) |
               ((state == MEM_WAIT) & ~dmem_ready & (waitCnt < WAIT_LAST));
    branchFlush = ~memStall & ex_branch_taken;
    // r0 is hardwired to zero, so a load into it can never create a hazard.
    loadUse = ~memStall & ~ex_branch_taken & idex_mem_read & (idex_rt != 5'd0) &
              ((idex_rt == id_rs) | (idex_rt == id_rt));
  end

  always_comb begin
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b1;
    if (!rst) begin
      dmem_req = (state == MEM_WAIT) | memOp;
      if (memStall) begin
        memwb_bubble = 1'b1;
      end else if (branchFlush) begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        memwb_bubble = 1'b0;
      end else if (loadUse) begin
        // Hold PC and IF/ID; ID/EX takes the bubble while the load moves on.
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        idex_flush   = 1'b1;
        memwb_bubble = 1'b0;
      end else begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      waitCnt     <= '0;
      stall_count <= '0;
      mem_err     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memOp && !dmem_ready) begin
            state   <= MEM_WAIT;
            waitCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (waitCnt == WAIT_LAST) begin
            // Timeout: drop the access and let the pipe advance.
            state   <= RUN;
            waitCnt <= '0;
            mem_err <= 1'b1;
          end else begin
            waitCnt <= waitCnt + TO_W'(1);
          end
        end
        default: state <= RUN;
      endcase
      if ((memStall || loadUse) && !(&stall_count))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
